dram_req_queue_mc: RTL and testbench

Multi-channel, parametrised DRAM request queue between the scratchpad backends and the DRAM controller. Each of NUM_CH backends pushes read or write sub-requests into its own DEPTH-entry FIFO. A burst-locking round-robin arbiter forwards one sub-request per cycle to the controller, so every burst reaches DRAM contiguously. The block reports per-channel burst completion back to the originating backend.

---
 rtl/dram_req_queue_mc_if.sv | 53 +++++
 rtl/dram_req_queue_mc.sv | 182 ++++++++++++++++++
 tb/tb_dram_req_queue_mc.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_req_queue_mc_if.sv
// Backend-push and controller-side request bus of the multi-channel DRAM request queue.
// Per-channel fields are flattened, with channel c occupying slice c.
interface dram_req_queue_mc_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned NUM_CH = 2
);
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH-1:0]        in_write;
    logic [NUM_CH*ADDR_W-1:0] in_addr;
    logic [NUM_CH*ID_W-1:0]   in_id;
    logic [NUM_CH*3-1:0]      in_sub_id;
    logic [NUM_CH*3-1:0]      in_num_req;
    logic [NUM_CH*MASK_W-1:0] in_mask;
    logic [NUM_CH*DATA_W-1:0] in_wdata;

    logic                     out_valid;
    logic                     out_ready;
    logic                     out_write;
    logic [ADDR_W-1:0]        out_addr;
    logic [ID_W-1:0]          out_id;
    logic [2:0]               out_sub_id;
    logic [MASK_W-1:0]        out_mask;
    logic [DATA_W-1:0]        out_wdata;
    logic [CH_W-1:0]          out_ch;

    logic [NUM_CH*CNT_W-1:0]  count;
    logic [NUM_CH-1:0]        burst_done;
    logic [ID_W-1:0]          burst_done_id;

    modport slave (
        input  in_valid, in_write, in_addr, in_id, in_sub_id, in_num_req, in_mask, in_wdata,
        input  out_ready,
        output in_ready,
        output out_valid, out_write, out_addr, out_id, out_sub_id, out_mask, out_wdata, out_ch,
        output count, burst_done, burst_done_id
    );

    modport master (
        output in_valid, in_write, in_addr, in_id, in_sub_id, in_num_req, in_mask, in_wdata,
        output out_ready,
        input  in_ready,
        input  out_valid, out_write, out_addr, out_id, out_sub_id, out_mask, out_wdata, out_ch,
        input  count, burst_done, burst_done_id
    );
endinterface

// File: rtl/dram_req_queue_mc.sv
// Per-channel FWFT request FIFOs feeding a burst-locking round-robin arbiter
// towards the DRAM controller, with registered per-channel burst completion.
module dram_req_queue_mc #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned NUM_CH = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 flush,
    dram_req_queue_mc_if.slave   bus
);
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [2:0]        sub_id;
        logic              last;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    typedef enum logic {
        IDLE_RR,
        LOCKED
    } arb_state_t;

    logic [PTR_W-1:0] wr_ptr [NUM_CH];
    logic [PTR_W-1:0] rd_ptr [NUM_CH];
    logic [CNT_W-1:0] cnt    [NUM_CH];
    entry_t           head   [NUM_CH];
    logic [NUM_CH-1:0] push, pop, full, empty;

    arb_state_t       state_q, state_d;
    logic [CH_W-1:0]  lock_ch_q, lock_ch_d;
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]  grant;
    logic             found;
    int unsigned      idx;
    entry_t           head_g;
    logic             valid, hs;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [ID_W-1:0]  done_id_q, done_id_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        entry_t mem [DEPTH];
        entry_t in_e;

        assign full[c]         = (cnt[c] == CNT_W'(DEPTH));
        assign empty[c]        = (cnt[c] == '0);
        assign bus.in_ready[c] = ~full[c];
        assign push[c]         = bus.in_valid[c] & ~full[c] & ~flush;
        assign pop[c]          = hs & (grant == CH_W'(c)) & ~flush;
        assign bus.count[c*CNT_W +: CNT_W] = cnt[c];

        assign in_e.write  = bus.in_write[c];
        assign in_e.addr   = bus.in_addr[c*ADDR_W +: ADDR_W];
        assign in_e.id     = bus.in_id[c*ID_W +: ID_W];
        assign in_e.sub_id = bus.in_sub_id[c*3 +: 3];
        // 3-bit wrap makes num_req=0 mark sub_id 7 as the last beat
        assign in_e.last   = (bus.in_sub_id[c*3 +: 3] == 3'(bus.in_num_req[c*3 +: 3] - 3'd1));
        assign in_e.mask   = bus.in_mask[c*MASK_W +: MASK_W];
        assign in_e.wdata  = bus.in_write[c] ? bus.in_wdata[c*DATA_W +: DATA_W] : '0;

        always_ff @(posedge CLK) begin
            if (push[c]) begin
                mem[wr_ptr[c]] <= in_e;
            end
        end

        assign head[c] = mem[rd_ptr[c]];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                if (push[i] && !pop[i])      cnt[i] <= cnt[i] + CNT_W'(1);
                else if (!push[i] && pop[i]) cnt[i] <= cnt[i] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        grant = rr_ptr_q;
        found = 1'b0;
        idx   = 0;
        if (state_q == LOCKED) begin
            grant = lock_ch_q;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                idx = i + 32'(rr_ptr_q);
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                if (!found && !empty[idx]) begin
                    grant = CH_W'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    assign head_g = head[grant];
    assign valid  = ~empty[grant];
    assign hs     = valid & bus.out_ready;

    assign bus.out_valid  = valid;
    assign bus.out_ch     = grant;
    assign bus.out_write  = valid ? head_g.write  : 1'b0;
    assign bus.out_addr   = valid ? head_g.addr   : '0;
    assign bus.out_id     = valid ? head_g.id     : '0;
    assign bus.out_sub_id = valid ? head_g.sub_id : '0;
    assign bus.out_mask   = valid ? head_g.mask   : '0;
    assign bus.out_wdata  = valid ? head_g.wdata  : '0;

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        rr_ptr_d  = rr_ptr_q;
        done_d    = '0;
        done_id_d = done_id_q;
        if (hs) begin
            if (head_g.last) begin
                state_d      = IDLE_RR;
                rr_ptr_d     = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
                done_d[grant] = 1'b1;
                done_id_d    = head_g.id;
            end else begin
                state_d   = LOCKED;
                lock_ch_d = grant;
            end
        end else if (state_q == IDLE_RR && valid) begin
            // A stalled grant is non-empty, so restarting the scan at it keeps it
            // granted even if an earlier channel in scan order fills meanwhile.
            rr_ptr_d = grant;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE_RR;
            lock_ch_q <= '0;
            rr_ptr_q  <= '0;
            done_q    <= '0;
            done_id_q <= '0;
        end else if (flush) begin
            state_q   <= IDLE_RR;
            lock_ch_q <= '0;
            rr_ptr_q  <= '0;
            done_q    <= '0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            rr_ptr_q  <= rr_ptr_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign bus.burst_done    = done_q;
    assign bus.burst_done_id = done_id_q;
endmodule

// File: tb/tb_dram_req_queue_mc.sv
// Bench for dram_req_queue_mc: directed scenarios then random traffic, every cycle
// compared against a queue-based model of the channel FIFOs and burst arbitration.
module tb_dram_req_queue_mc;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [2:0]        sub_id;
        logic              last;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] wdata;
    } exp_t;

    logic CLK;
    logic nRST;
    logic flush;

    dram_req_queue_mc_if #(
        .ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)
    ) bus ();

    dram_req_queue_mc #(
        .ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .flush(flush),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // model state
    exp_t              q [NUM_CH][$];
    int                owner;
    int                hold;
    int                rr;
    logic [NUM_CH-1:0] bd_mask;
    logic [ID_W-1:0]   bd_id;

    // stimulus burst generators
    int              gen_len  [NUM_CH];
    int              gen_sub  [NUM_CH];
    int              dir_len  [NUM_CH];
    logic [ID_W-1:0] gen_id   [NUM_CH];
    logic            gen_write[NUM_CH];
    logic [ADDR_W-1:0] gen_addr[NUM_CH];
    exp_t            drv      [NUM_CH];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_burst(input int c);
        gen_len[c]   = (dir_len[c] != 0) ? dir_len[c] : int'($urandom_range(1, 8));
        gen_sub[c]   = 0;
        gen_id[c]    = ID_W'($urandom);
        gen_write[c] = 1'($urandom);
        gen_addr[c]  = ADDR_W'($urandom) & ~ADDR_W'(255);
    endtask

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            q[c].delete();
            new_burst(c);
        end
        owner   = -1;
        hold    = -1;
        rr      = 0;
        bd_mask = '0;
        bd_id   = '0;
    endtask

    task automatic drive(input int c, input bit en);
        logic [2:0]        nreq;
        logic [MASK_W-1:0] m;
        logic [DATA_W-1:0] d;
        bus.in_valid[c] = en;
        if (en) begin
            nreq = 3'(gen_len[c] % 8);
            m    = MASK_W'($urandom);
            d    = {$urandom, $urandom, $urandom, $urandom};
            bus.in_write[c]                    = gen_write[c];
            bus.in_addr[c*ADDR_W +: ADDR_W]    = gen_addr[c] + ADDR_W'(gen_sub[c] * 16);
            bus.in_id[c*ID_W +: ID_W]          = gen_id[c];
            bus.in_sub_id[c*3 +: 3]            = 3'(gen_sub[c]);
            bus.in_num_req[c*3 +: 3]           = nreq;
            bus.in_mask[c*MASK_W +: MASK_W]    = m;
            bus.in_wdata[c*DATA_W +: DATA_W]   = d;
            drv[c].write  = gen_write[c];
            drv[c].addr   = gen_addr[c] + ADDR_W'(gen_sub[c] * 16);
            drv[c].id     = gen_id[c];
            drv[c].sub_id = 3'(gen_sub[c]);
            drv[c].last   = (gen_sub[c] == ((int'(nreq) + 7) % 8));
            drv[c].mask   = m;
            drv[c].wdata  = gen_write[c] ? d : '0;
        end
    endtask

    // Called at posedge+1 with inputs driven; checks outputs, then advances one cycle.
    task automatic tick();
        int                g;
        bit                ev;
        bit                do_pop;
        bit                fl;
        logic [NUM_CH-1:0] acc;
        exp_t              e;
        #1;
        if (owner >= 0) g = owner;
        else if (hold >= 0) g = hold;
        else begin
            g = rr;
            for (int i = 0; i < NUM_CH; i++) begin
                if (q[(rr + i) % NUM_CH].size() != 0) begin
                    g = (rr + i) % NUM_CH;
                    break;
                end
            end
        end
        ev = (q[g].size() != 0);
        chk("out_valid", bus.out_valid, ev);
        for (int c = 0; c < NUM_CH; c++) begin
            chk("in_ready", bus.in_ready[c], q[c].size() != DEPTH);
            chk("count", bus.count[c*CNT_W +: CNT_W], q[c].size());
        end
        chk("burst_done", bus.burst_done, bd_mask);
        if (bd_mask != 0) chk("burst_done_id", bus.burst_done_id, bd_id);
        if (ev) begin
            e = q[g][0];
            chk("out_ch", bus.out_ch, g);
            chk("out_write", bus.out_write, e.write);
            chk("out_addr", bus.out_addr, e.addr);
            chk("out_id", bus.out_id, e.id);
            chk("out_sub_id", bus.out_sub_id, e.sub_id);
            chk("out_mask", bus.out_mask, e.mask);
            chk("out_wdata", bus.out_wdata, e.wdata);
        end else if (owner >= 0) begin
            chk("out_ch_locked", bus.out_ch, owner);
        end
        fl     = flush;
        do_pop = ev && bus.out_ready;
        for (int c = 0; c < NUM_CH; c++)
            acc[c] = bus.in_valid[c] && (q[c].size() < DEPTH) && !fl;
        @(posedge CLK);
        #1;
        bd_mask = '0;
        if (fl) begin
            model_clear();
        end else begin
            if (do_pop) begin
                e    = q[g].pop_front();
                hold = -1;
                if (e.last) begin
                    owner      = -1;
                    rr         = (g + 1) % NUM_CH;
                    bd_mask[g] = 1'b1;
                    bd_id      = e.id;
                end else begin
                    owner = g;
                end
            end else begin
                hold = (ev && owner < 0) ? g : -1;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (acc[c]) begin
                    q[c].push_back(drv[c]);
                    gen_sub[c]++;
                    if (gen_sub[c] == gen_len[c]) new_burst(c);
                end
            end
        end
    endtask

    // Asserts nRST mid-cycle, checks reset values immediately, releases after an edge.
    task automatic do_reset();
        for (int c = 0; c < NUM_CH; c++) bus.in_valid[c] = 1'b0;
        flush = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, {NUM_CH{1'b1}});
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_write", bus.out_write, 1'b0);
        chk("rst_out_addr", bus.out_addr, '0);
        chk("rst_out_id", bus.out_id, '0);
        chk("rst_out_sub_id", bus.out_sub_id, '0);
        chk("rst_out_mask", bus.out_mask, '0);
        chk("rst_out_wdata", bus.out_wdata, '0);
        chk("rst_out_ch", bus.out_ch, '0);
        chk("rst_count", bus.count, '0);
        chk("rst_burst_done", bus.burst_done, '0);
        chk("rst_burst_done_id", bus.burst_done_id, '0);
        model_clear();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        nRST           = 1'b0;
        flush          = 1'b0;
        bus.in_valid   = '0;
        bus.in_write   = '0;
        bus.in_addr    = '0;
        bus.in_id      = '0;
        bus.in_sub_id  = '0;
        bus.in_num_req = '0;
        bus.in_mask    = '0;
        bus.in_wdata   = '0;
        bus.out_ready  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) dir_len[c] = 0;
        @(posedge CLK);
        #1;
        do_reset();

        // single channel, 4-beat burst, controller always ready
        dir_len[0] = 4;
        new_burst(0);
        bus.out_ready = 1'b1;
        repeat (4) begin drive(0, 1); drive(1, 0); tick(); end
        drive(0, 0);
        repeat (3) tick();

        // two channels with simultaneous 2-beat bursts, twice (second round starts at ch1)
        dir_len[0] = 2; dir_len[1] = 2;
        new_burst(0); new_burst(1);
        repeat (2) begin
            repeat (2) begin drive(0, 1); drive(1, 1); tick(); end
            drive(0, 0); drive(1, 0);
            repeat (5) tick();
        end

        // flush with a same-cycle push discards the push
        drive(0, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(0, 0);
        repeat (2) tick();

        // lock with gap: ch0 sends sub 0, ch1 full burst waits until ch0 finishes
        new_burst(0); new_burst(1);
        drive(0, 1); drive(1, 1); tick();
        drive(0, 0); drive(1, 1); tick();
        drive(1, 0);
        repeat (3) tick();
        drive(0, 1); tick();
        drive(0, 0);
        repeat (5) tick();

        // fill ch0 with num_req=0 (8-beat) bursts while stalled, then release
        dir_len[0] = 8;
        new_burst(0);
        bus.out_ready = 1'b0;
        repeat (10) begin drive(0, 1); tick(); end
        bus.out_ready = 1'b1;
        repeat (8) begin drive(0, 1); tick(); end
        drive(0, 0);
        repeat (20) tick();

        // nRST asserted mid-burst
        dir_len[0] = 4;
        new_burst(0);
        repeat (3) begin drive(0, 1); tick(); end
        do_reset();
        repeat (3) tick();

        // random traffic
        for (int c = 0; c < NUM_CH; c++) dir_len[c] = 0;
        model_clear();
        for (int ph = 0; ph < 6; ph++) begin
            int p0, p1, pr;
            p0 = int'($urandom_range(10, 95));
            p1 = int'($urandom_range(10, 95));
            pr = int'($urandom_range(20, 100));
            repeat (500) begin
                drive(0, $urandom_range(0, 99) < p0);
                drive(1, $urandom_range(0, 99) < p1);
                bus.out_ready = ($urandom_range(0, 99) < pr);
                flush = ($urandom_range(0, 249) == 0);
                if ($urandom_range(0, 999) == 0) do_reset();
                else tick();
            end
        end
        flush = 1'b0;
        drive(0, 0); drive(1, 0);
        bus.out_ready = 1'b1;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
